// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit: per-register pending-write counters drive ID stalls.
// Optional stall-cycle counter enabled by defining HAZ_STALL_CNT_EN.
module hazard_scoreboard #(
    parameter int NREGS     = 16,
    parameter int RIDX_W    = 4,
    parameter int CNT_W     = 2,
    parameter int R0_ZERO   = 1,
    parameter int WB_BYPASS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [RIDX_W-1:0] id_rs1,
    input  logic [RIDX_W-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [RIDX_W-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic              wb_valid,
    input  logic [RIDX_W-1:0] wb_rd,
    input  logic              kill_valid,
    input  logic [RIDX_W-1:0] kill_rd,
    input  logic              mc_busy,
    output logic              if_id_stall,
    output logic              id_ex_stall,
    output logic              issue,
    output logic [NREGS-1:0]  pending,
    output logic [15:0]       stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt     [NREGS];
    logic [CNT_W-1:0] cnt_nxt [NREGS];

    logic rs1_trk, rs2_trk, rd_trk;
    logic rs1_byp, rs2_byp;
    logic rs1_haz, rs2_haz, sat_haz;
    logic stall;

    // Register 0 is never tracked when hardwired.
    assign rs1_trk = !(R0_ZERO != 0 && id_rs1 == '0);
    assign rs2_trk = !(R0_ZERO != 0 && id_rs2 == '0);
    assign rd_trk  = !(R0_ZERO != 0 && id_rd == '0);

    // Same-cycle writeback of the last outstanding write frees the source.
    assign rs1_byp = (WB_BYPASS != 0) && wb_valid &&
                     wb_rd == id_rs1 && cnt[id_rs1] == CNT_ONE;
    assign rs2_byp = (WB_BYPASS != 0) && wb_valid &&
                     wb_rd == id_rs2 && cnt[id_rs2] == CNT_ONE;

    assign rs1_haz = id_rs1_used && rs1_trk &&
                     cnt[id_rs1] != '0 && !rs1_byp;
    assign rs2_haz = id_rs2_used && rs2_trk &&
                     cnt[id_rs2] != '0 && !rs2_byp;
    assign sat_haz = id_valid && id_rd_we && rd_trk &&
                     cnt[id_rd] == CNT_MAX;

    assign stall = id_valid &&
                   (rs1_haz || rs2_haz || sat_haz || mc_busy);

    assign if_id_stall = stall;
    assign id_ex_stall = stall;
    assign issue       = id_valid && !stall;

    genvar r;
    for (r = 0; r < NREGS; r++) begin : g_reg
        assign pending[r] = |cnt[r];
        if (R0_ZERO != 0 && r == 0) begin : g_zero
            assign cnt_nxt[r] = '0;
        end else begin : g_cnt
            logic             inc;
            logic [1:0]       dec;
            logic [CNT_W:0]   up;
            logic [CNT_W:0]   dn;
            assign inc = issue && id_rd_we && id_rd == RIDX_W'(r);
            assign dec = 2'(wb_valid && wb_rd == RIDX_W'(r)) +
                         2'(kill_valid && kill_rd == RIDX_W'(r));
            assign up  = {1'b0, cnt[r]} + (CNT_W+1)'(inc);
            assign dn  = (CNT_W+1)'(dec);
            // Over-decrement is a protocol error; clamp at zero.
            assign cnt_nxt[r] = (up < dn) ? '0 : CNT_W'(up - dn);
        end
    end

    // Pending counters; reset drops all in-flight tracking.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            cnt[i] <= rst ? '0 : cnt_nxt[i];
        end
    end

`ifdef HAZ_STALL_CNT_EN
    logic [15:0] sc_q;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            sc_q <= '0;
        end else if (stall && sc_q != 16'hFFFF) begin
            sc_q <= sc_q + 16'd1;
        end
    end

    assign stall_cycles = sc_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic
// compared against an integer-array reference model.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used, id_rd_we;
    logic        wb_valid, kill_valid, mc_busy;
    logic [3:0]  wb_rd, kill_rd;
    logic        if_id_stall, id_ex_stall, issue;
    logic [15:0] pending;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    int m_cnt [16];
    int m_sc;
    logic e_stall, e_issue;
    logic [15:0] e_pend;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_rd_we     (id_rd_we),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .kill_valid   (kill_valid),
        .kill_rd      (kill_rd),
        .mc_busy      (mc_busy),
        .if_id_stall  (if_id_stall),
        .id_ex_stall  (id_ex_stall),
        .issue        (issue),
        .pending      (pending),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference: hazards from spec rules over integer counters.
    task automatic model_eval();
        logic h1, h2, hs;
        h1 = id_rs1_used && id_rs1 != 0 && m_cnt[id_rs1] > 0;
        h2 = id_rs2_used && id_rs2 != 0 && m_cnt[id_rs2] > 0;
        hs = id_rd_we && id_rd != 0 && m_cnt[id_rd] == 3;
        e_stall = id_valid && (h1 || h2 || hs || mc_busy);
        e_issue = id_valid && !e_stall;
        for (int i = 0; i < 16; i++) e_pend[i] = (m_cnt[i] != 0);
    endtask

    task automatic model_step();
        if (rst) begin
            for (int i = 0; i < 16; i++) m_cnt[i] = 0;
            m_sc = 0;
        end else begin
            if (e_issue && id_rd_we && id_rd != 0) m_cnt[id_rd]++;
            if (wb_valid) m_cnt[wb_rd]--;
            if (kill_valid) m_cnt[kill_rd]--;
            for (int i = 0; i < 16; i++)
                if (m_cnt[i] < 0 || i == 0) m_cnt[i] = 0;
            if (e_stall && m_sc < 65535) m_sc++;
        end
    endtask

    // Check all outputs against the model mid-cycle.
    task automatic settle();
        #3;
        model_eval();
        chk("if_id_stall", 32'(if_id_stall), 32'(e_stall));
        chk("id_ex_stall", 32'(id_ex_stall), 32'(e_stall));
        chk("issue", 32'(issue), 32'(e_issue));
        chk("pending", 32'(pending), 32'(e_pend));
`ifdef HAZ_STALL_CNT_EN
        chk("stall_cycles", 32'(stall_cycles), 32'(m_sc));
`else
        chk("stall_cycles", 32'(stall_cycles), 32'd0);
`endif
    endtask

    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_used = 0; id_rs2_used = 0; id_rd_we = 0;
        wb_valid = 0; wb_rd = 0; kill_valid = 0; kill_rd = 0;
        mc_busy = 0;
    endtask

    task automatic wr(input logic [3:0] rd);
        idle(); id_valid = 1; id_rd = rd; id_rd_we = 1;
    endtask

    task automatic rd1(input logic [3:0] s);
        idle(); id_valid = 1; id_rs1 = s; id_rs1_used = 1;
    endtask

    task automatic do_reset();
        idle(); rst = 1;
        settle();
        adv();
        rst = 0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;
        m_sc = 0;
        idle(); rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;

        // Reset state
        id_valid = 1;
        settle();
        chk("rst_stall", 32'(if_id_stall), 0);
        chk("rst_issue", 32'(issue), 1);
        chk("rst_pend", 32'(pending), 0);
        adv();

        // RAW on r3
        do_reset();
        wr(3); settle(); chk("raw_c0_issue", 32'(issue), 1); adv();
        for (int c = 1; c <= 4; c++) begin
            rd1(3);
            if (c == 4) begin wb_valid = 1; wb_rd = 3; end
            settle();
            chk("raw_stall", 32'(id_ex_stall), 1);
            adv();
        end
        rd1(3); settle(); chk("raw_c5_issue", 32'(issue), 1); adv();

        // Saturation on r5
        do_reset();
        for (int c = 0; c < 3; c++) begin
            wr(5); settle(); chk("sat_issue", 32'(issue), 1); adv();
        end
        for (int c = 0; c < 3; c++) begin
            wr(5);
            if (c == 2) begin wb_valid = 1; wb_rd = 5; end
            settle();
            chk("sat_stall", 32'(if_id_stall), 1);
            chk("sat_pend5", 32'(pending[5]), 1);
            adv();
        end
        wr(5); settle(); chk("sat_release", 32'(issue), 1);
        chk("sat_pend5b", 32'(pending[5]), 1); adv();

        // Same-cycle inc/dec, then double dec
        do_reset();
        wr(7); settle(); adv();
        wr(7); settle(); adv();
        wr(7); wb_valid = 1; wb_rd = 7; settle();
        chk("incdec_issue", 32'(issue), 1); adv();
        idle(); wb_valid = 1; wb_rd = 7; kill_valid = 1; kill_rd = 7;
        settle(); chk("incdec_pend7", 32'(pending[7]), 1); adv();
        idle(); settle(); chk("dbl_dec_pend7", 32'(pending[7]), 0); adv();

        // R0, unused source, mc_busy
        do_reset();
        wr(0); settle(); chk("r0_wr_issue", 32'(issue), 1); adv();
        rd1(0); settle(); chk("r0_rd_nostall", 32'(if_id_stall), 0); adv();
        wr(4); settle(); adv();
        idle(); id_valid = 1; id_rs2 = 4; id_rs2_used = 0;
        settle(); chk("unused_rs2", 32'(if_id_stall), 0); adv();
        idle(); id_valid = 1; id_rs2 = 4; id_rs2_used = 1;
        settle(); chk("used_rs2", 32'(if_id_stall), 1); adv();
        idle(); id_valid = 1; mc_busy = 1; id_rs1 = 9; id_rs1_used = 1;
        settle(); chk("mc_busy", 32'(id_ex_stall), 1); adv();

        // Reset mid-flight with pending 0x0028
        do_reset();
        wr(3); settle(); adv();
        wr(5); settle(); adv();
        idle(); settle(); chk("mid_pend", 32'(pending), 32'h28); adv();
        rd1(3); settle(); adv();
        rd1(3); rst = 1; wb_valid = 1; wb_rd = 3; settle(); adv();
        rd1(3); settle();
        chk("post_rst_pend", 32'(pending), 0);
        chk("post_rst_stall", 32'(if_id_stall), 0);
        chk("post_rst_sc", 32'(stall_cycles), 0);
        adv();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            rst         = ($urandom_range(0, 99) == 0);
            id_valid    = ($urandom_range(0, 9) < 8);
            id_rs1      = 4'($urandom_range(0, 7));
            id_rs2      = 4'($urandom_range(0, 7));
            id_rd       = 4'($urandom_range(0, 7));
            id_rs1_used = 1'($urandom);
            id_rs2_used = 1'($urandom);
            id_rd_we    = ($urandom_range(0, 3) != 0);
            wb_valid    = ($urandom_range(0, 9) < 4);
            wb_rd       = 4'($urandom_range(0, 7));
            kill_valid  = ($urandom_range(0, 9) == 0);
            kill_rd     = 4'($urandom_range(0, 7));
            mc_busy     = ($urandom_range(0, 9) == 0);
            settle();
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised scoreboard hazard unit; next generation of the decode-stage hazard control. It tracks in-flight register writes with per-register pending counters instead of comparing against fixed EX/MEM/WB destination fields, so it scales with register count and pipeline depth. It sits beside the ID stage and drives the IF/ID and ID/EX stall lines. It also stalls on a busy multi-cycle unit and can optionally bypass same-cycle writebacks.

## Interface
Parameters:
- NREGS, 16, number of architectural registers (power of two, ≥2)
- RIDX_W, 4, register index width, equal to log2(NREGS)
- CNT_W, 2, pending-counter width; max in-flight writes per register = 2^CNT_W−1
- R0_ZERO, 1, 1: register 0 is hardwired, never tracked and never hazards
- WB_BYPASS, 0, 1: a writeback in the current cycle clears a hazard whose count is exactly 1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_rs1 / id_rs2  in  RIDX_W  source indices
- id_rs1_used / id_rs2_used  in  1  source actually read
- id_rd  in  RIDX_W  destination index
- id_rd_we  in  1  instruction writes id_rd
- wb_valid  in  1  a register write retires this cycle
- wb_rd  in  RIDX_W  retiring destination
- kill_valid  in  1  a squashed in-flight write is cancelled this cycle
- kill_rd  in  RIDX_W  cancelled destination
- mc_busy  in  1  multi-cycle unit cannot accept an issue
- if_id_stall  out  1  hold IF/ID
- id_ex_stall  out  1  hold ID/EX (insert bubble)
- issue  out  1  the instruction in ID advances this cycle
- pending  out  NREGS  bit r = counter r nonzero
- stall_cycles  out  16  stall-cycle count (macro only, otherwise 0)

## Operation
- State: cnt[r], CNT_W bits, r = 0..NREGS−1. With R0_ZERO=1, cnt[0] is constant 0.
- src_haz(s) = used_s && tracked(s) && cnt[s]≠0 && !(WB_BYPASS && wb_valid && wb_rd==s && cnt[s]==1).
- sat_haz = id_valid && id_rd_we && tracked(id_rd) && cnt[id_rd] == 2^CNT_W−1.
- stall = id_valid && (src_haz(rs1) || src_haz(rs2) || sat_haz || mc_busy).
- if_id_stall = id_ex_stall = stall. issue = id_valid && !stall.
- Per-cycle update for register r:
  - inc = issue && id_rd_we && id_rd==r
  - dec = (wb_valid && wb_rd==r) + (kill_valid && kill_rd==r), range 0..2
  - cnt[r] ← cnt[r] + inc − dec
- Inc and one dec on the same register in the same cycle leaves the count unchanged.
- Decrementing below 0 is a pipeline protocol error. The counter clamps at 0. No assertion output.
- Increment never wraps, because sat_haz blocks it.
- id_rd_we to register 0 with R0_ZERO=1: no increment, no stall.
- pending[r] = (cnt[r]≠0).

## Timing
- Stall outputs are combinational from registered cnt and the current inputs. Zero-cycle decision.
- Counter update takes effect at the next rising clk.
- With WB_BYPASS=0, a writeback in cycle N releases a dependent stall in cycle N+1.
- With WB_BYPASS=1, the stall releases in cycle N itself, but only when cnt==1.
- Reset: all cnt←0 and stall_cycles←0. Outputs after reset are if_id_stall=0, id_ex_stall=0, issue=id_valid, pending=0.
- Reset mid-operation discards all in-flight tracking, and writebacks arriving in the same cycle as rst are ignored. The pipeline must flush alongside.

## Configuration
- HAZ_STALL_CNT_EN defined: stall_cycles increments each cycle where stall=1 and saturates at 16'hFFFF. Reset clears it.
- HAZ_STALL_CNT_EN undefined: no counter flops; stall_cycles is tied to 0.

## Test plan
- RAW on one register: issue rd=3 at cycle 0, then ID reads rs1=3 at cycle 1, then wb_rd=3 at cycle 4.
  - Required: stall high in cycles 1–4, issue in cycle 5 (WB_BYPASS=0).
  - With WB_BYPASS=1: issue in cycle 4.
- Saturation (CNT_W=2): three back-to-back writes to r5 issue; a fourth write to r5 stalls until a wb_rd=5 arrives, then issues the cycle after.
  - Required: pending[5] stays 1 throughout.
- Same-cycle inc/dec and double dec:
  - cnt[7]=2 with issue rd=7 and wb_rd=7 in one cycle → cnt[7]=2.
  - wb_rd=7 and kill_rd=7 in the next cycle → cnt[7]=0.
- R0 and unused sources:
  - rs1=0 with a write to r0 in flight → no stall.
  - rs2_used=0 with rs2=4 while r4 is pending → no stall.
  - mc_busy=1 with no RAW → stall.
- Reset mid-flight: pending=16'h0028, assert rst for one cycle.
  - Required: pending=0 and stall=0 next cycle; with HAZ_STALL_CNT_EN, stall_cycles=0.
